// File: rtl/mux_scan_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mux_scan_sequencer: steps a 4-way mux through every select, samples it.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mux_scan_sequencer #(
    parameter int IN_W          = 3,
    parameter int SEL_W         = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       pattern,
    input  logic                  mux_out,
    output logic [IN_W-1:0]       mux_in,
    output logic [SEL_W-1:0]      mux_sel,
    output logic                  busy,
    output logic                  done,
    output logic [(2**SEL_W)-1:0] result,
    output logic                  result_valid
);

    localparam int N     = 2 ** SEL_W;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [IN_W-1:0]  r_mux_in;
    logic [IN_W-1:0]  w_mux_in_nxt;
    logic [SEL_W-1:0] r_mux_sel;
    logic [SEL_W-1:0] w_mux_sel_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic [N-1:0]     r_result;
    logic [N-1:0]     w_result_nxt;
    logic             r_result_valid;
    logic             w_result_valid_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_mux_in       <= '0;
            r_mux_sel      <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_mux_in       <= w_mux_in_nxt;
            r_mux_sel      <= w_mux_sel_nxt;
            r_busy         <= w_busy_nxt;
            r_done         <= w_done_nxt;
            r_result       <= w_result_nxt;
            r_result_valid <= w_result_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_cnt_nxt          = r_cnt;
        w_mux_in_nxt       = r_mux_in;
        w_mux_sel_nxt      = r_mux_sel;
        w_busy_nxt         = r_busy;
        w_done_nxt         = r_done;
        w_result_nxt       = r_result;
        w_result_valid_nxt = r_result_valid;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt        = ST_SCAN;
                    w_mux_in_nxt       = pattern;
                    w_mux_sel_nxt      = '0;
                    w_cnt_nxt          = '0;
                    w_result_nxt       = '0;
                    w_result_valid_nxt = 1'b0;
                    w_busy_nxt         = 1'b1;
                end
            end
            ST_SCAN: begin
                if (r_cnt != CNT_LAST) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else begin
                    // Only the last cycle of each hold is sampled, so settling glitches are ignored.
                    w_result_nxt[r_mux_sel] = mux_out;
                    if (r_mux_sel == SEL_LAST) begin
                        w_state_nxt        = ST_DONE;
                        w_busy_nxt         = 1'b0;
                        w_done_nxt         = 1'b1;
                        w_result_valid_nxt = 1'b1;
                    end else begin
                        w_mux_sel_nxt = r_mux_sel + SEL_W'(1);
                        w_cnt_nxt     = '0;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign mux_in       = r_mux_in;
    assign mux_sel      = r_mux_sel;
    assign busy         = r_busy;
    assign done         = r_done;
    assign result       = r_result;
    assign result_valid = r_result_valid;

endmodule
`default_nettype wire
